af_input_arbiter: RTL
=====================

// Module: af_input_arbiter
// PURPOSE
//  Round-robin arbiter that shares one activationFunction unit among NUM_REQ accumulator lanes.
//  Buffers one item per lane, picks a winner each un-halted cycle and drives the registered
//  ACC_AF_* bus. Tracks the lane id so the NI can tag the AF_NI_packet leaving the AF stage.
//  Sits between the accumulator lanes and the activationFunction input; shares hlt with the AF.
// PARAMETERS
//  NUM_REQ       4   number of accumulator lanes
//  REQ_ID_WIDTH  2   lane-id width, must equal clog2(NUM_REQ)
//  (TYPE_WIDTH, SEQ_WIDTH, SSUM_WIDTH and type code DATA come from header.vh)
// PORTS
//  clk            in   1                     clock; all logic on posedge
//  rst            in   1                     synchronous, active-low reset (0 = reset)
//  hlt            in   1                     global stall; same net that drives the AF hlt
//  req_valid      in   NUM_REQ               lane i offers an item
//  req_ready      out  NUM_REQ               lane i item accepted at this edge if valid
//  req_type       in   NUM_REQ*TYPE_WIDTH    packed per lane, lane0 in LSBs
//  req_seqNum     in   NUM_REQ*SEQ_WIDTH     packed per lane
//  req_data       in   NUM_REQ*SSUM_WIDTH    packed per lane, signed partial sum
//  ACC_AF_valid   out  1                     registered; to AF
//  ACC_AF_type    out  TYPE_WIDTH            registered; to AF
//  ACC_AF_seqNum  out  SEQ_WIDTH             registered; to AF
//  ACC_AF_data    out  SSUM_WIDTH            registered; to AF
//  grant_id       out  REQ_ID_WIDTH          lane id of the item on ACC_AF_*
//  af_src_id      out  REQ_ID_WIDTH          grant_id delayed one un-halted cycle; aligned with AF_NI_packet
//  stall_cnt      out  32                    only if AF_ARB_STATS_EN defined
// BEHAVIOUR
//  Reset (rst==0 at edge):
//   - hold_valid[*]=0, ACC_AF_*=0, grant_id=0, af_src_id=0, rr pointer=0.
//   - req_ready forced 0 while rst==0.
//  Holding regs: one entry per lane (valid/type/seq/data).
//   - req_ready[i] = rst & (!hold_valid[i] | (grant[i] & !hlt)).
//   - Load on req_valid[i]&req_ready[i]. Simultaneous drain and refill of the same lane is allowed.
//  Arbitration: combinational rr among hold_valid, starting at pointer.
//   - Gated by !hlt; at most one grant per cycle.
//   - On grant to lane k: output regs <= hold[k], grant_id<=k, hold_valid[k] cleared unless refilled, pointer<=(k+1) mod NUM_REQ.
//   - No lane valid and !hlt: ACC_AF_valid<=0, other outputs hold, pointer unchanged.
//  hlt==1:
//   - Output regs, grant_id, af_src_id and pointer frozen.
//   - No grant issued; empty holding regs may still load.
//  af_src_id<=grant_id on every !hlt edge. This mirrors the one-stage AF register, so af_src_id
//   tags the AF output packet.
//  Latency: lane accepted at edge E0 -> ACC_AF_valid at E1 earliest -> AF output at E2. All edges un-halted.
//  Throughput: one item per un-halted cycle. A lane with a permanent request gets >=1 of every NUM_REQ grants.
//  Non-DATA types are arbitrated and forwarded unchanged; the AF discards them.
//  Reset mid-operation: buffered and in-flight items are dropped; no partial state survives.
// CONFIGURATION
//  AF_ARB_STATS_EN defined:
//   - stall_cnt port exists: 32-bit saturating count of cycles with hlt==1 and any hold_valid set.
//   - Cleared by reset; saturates at 32'hFFFFFFFF.
//  AF_ARB_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  header.vh: TYPE_WIDTH, SEQ_WIDTH, SSUM_WIDTH, DATA type code (shared with the AF, accumulators and NI).
//  Sub-module rr_arbiter: NUM_REQ request vector + pointer -> one-hot grant + encoded id, purely combinational.
//   Reusable by the NI.
//  Top level holds the lane registers, output registers, pointer and optional counter.
// TESTING
//  1. Reset: rst=0 for 3 cycles with all req_valid=1 -> req_ready=0, ACC_AF_valid=0, grant_id=0.
//  2. Single lane: lane2 sends data=-5, seq=7, type=DATA.
//     -> next edge ACC_AF_data=-5, grant_id=2; one edge later af_src_id=2.
//  3. Fairness: all 4 lanes valid continuously.
//     -> grant_id sequence 0,1,2,3,0,1 and req_ready pulses once per 4 cycles per lane.
//  4. hlt: assert hlt for 5 cycles with lanes 1,3 holding.
//     -> ACC_AF_*, grant_id and pointer frozen. After release, lane1 then lane3 are granted.
//     -> With AF_ARB_STATS_EN defined: stall_cnt=5.
//  5. Same-cycle drain and refill: lane0 granted while req_valid[0]=1.
//     -> req_ready[0]=1, the new item is buffered and no item is lost or duplicated (check by seq numbers).
//  6. Reset mid-stream: rst=0 with 3 lanes buffered.
//     -> nothing appears after reset; the first post-reset grant goes to the lowest valid lane (pointer=0).

Source files
------------

// File: rtl/af_input_arbiter_pkg.sv
// Shared widths, type codes and item record for the accumulator -> activationFunction path.
// Widths and the DATA type code are the same ones the AF, accumulators and NI use.
package af_input_arbiter_pkg;

  localparam int TYPE_WIDTH = 2;
  localparam int SEQ_WIDTH  = 8;
  localparam int SSUM_WIDTH = 16;

  localparam logic [TYPE_WIDTH-1:0] TYPE_DATA = 2'd1;
  localparam logic [TYPE_WIDTH-1:0] TYPE_CFG  = 2'd2;

  typedef struct packed {
    logic [TYPE_WIDTH-1:0]        typ;
    logic [SEQ_WIDTH-1:0]         seq;
    logic signed [SSUM_WIDTH-1:0] data;
  } af_item_t;

  // Round-robin successor of lane id within num lanes.
  function automatic int rr_next(input int id, input int num);
    return (id + 1 >= num) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/af_input_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: request vector + start pointer -> one-hot grant and id.
// Reusable by the NI; holds no state.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld
);

  int idx;

  // Scan from the farthest offset down so the request nearest the pointer wins last.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
        gnt_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/af_input_arbiter.sv
// Round-robin arbiter sharing one activationFunction among NUM_REQ accumulator lanes.
// Optional AF_ARB_STATS_EN adds a saturating stall_cnt of halted cycles with buffered work.
module af_input_arbiter
  import af_input_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hlt,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*TYPE_WIDTH-1:0]  req_type,
  input  logic [NUM_REQ*SEQ_WIDTH-1:0]   req_seqNum,
  input  logic [NUM_REQ*SSUM_WIDTH-1:0]  req_data,
  output logic                           ACC_AF_valid,
  output logic [TYPE_WIDTH-1:0]          ACC_AF_type,
  output logic [SEQ_WIDTH-1:0]           ACC_AF_seqNum,
  output logic [SSUM_WIDTH-1:0]          ACC_AF_data,
  output logic [REQ_ID_WIDTH-1:0]        grant_id,
  output logic [REQ_ID_WIDTH-1:0]        af_src_id
`ifdef AF_ARB_STATS_EN
  ,
  output logic [31:0]                    stall_cnt
`endif
);

  logic [NUM_REQ-1:0]      hold_valid_q, hold_valid_d;
  af_item_t                hold_q [NUM_REQ];
  af_item_t                in_item [NUM_REQ];
  logic [REQ_ID_WIDTH-1:0] ptr_q, ptr_d;
  af_item_t                out_q;
  logic                    out_vld_q;
  logic [REQ_ID_WIDTH-1:0] gid_q, src_q;

  logic [NUM_REQ-1:0]      arb_req, grant, load;
  logic [REQ_ID_WIDTH-1:0] win_id;
  logic                    win_vld;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      in_item[i].typ  = req_type[i*TYPE_WIDTH +: TYPE_WIDTH];
      in_item[i].seq  = req_seqNum[i*SEQ_WIDTH +: SEQ_WIDTH];
      in_item[i].data = $signed(req_data[i*SSUM_WIDTH +: SSUM_WIDTH]);
    end
  end

  // Halting masks the requests, so no grant and no drain happen while hlt is high.
  assign arb_req = hold_valid_q & {NUM_REQ{~hlt}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (REQ_ID_WIDTH)
  ) u_rr (
    .req     (arb_req),
    .ptr     (ptr_q),
    .grant   (grant),
    .gnt_id  (win_id),
    .gnt_vld (win_vld)
  );

  assign req_ready    = {NUM_REQ{rst}} & (~hold_valid_q | grant);
  assign load         = req_valid & req_ready;
  assign hold_valid_d = (hold_valid_q & ~grant) | load;
  assign ptr_d        = REQ_ID_WIDTH'(rr_next(int'(win_id), NUM_REQ));

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid_q <= '0;
      out_vld_q    <= 1'b0;
      out_q        <= '0;
      gid_q        <= '0;
      src_q        <= '0;
      ptr_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      if (!hlt) begin
        // src_q mirrors the AF's single register stage so it tags the AF output.
        src_q     <= gid_q;
        out_vld_q <= win_vld;
        if (win_vld) begin
          out_q <= hold_q[win_id];
          gid_q <= win_id;
          ptr_q <= ptr_d;
        end
      end
    end
  end

  // Lane payloads are qualified by hold_valid_q and need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load[i]) hold_q[i] <= in_item[i];
    end
  end

  assign ACC_AF_valid  = out_vld_q;
  assign ACC_AF_type   = out_q.typ;
  assign ACC_AF_seqNum = out_q.seq;
  assign ACC_AF_data   = out_q.data;
  assign grant_id      = gid_q;
  assign af_src_id     = src_q;

`ifdef AF_ARB_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (hlt && (|hold_valid_q) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
